// File: rtl/serial_magnitude_cmp.sv
// Bit-serial magnitude comparator: MSB-first compare of A and B over WIDTH cycles.
// Define SERIAL_CMP_SIGNED_EN to enable two's-complement compares via sgn.
module serial_magnitude_cmp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sgn,
  output logic             busy,
  output logic             done,
  output logic             L,
  output logic             E,
  output logic             G
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {REL_EQ = 2'd0, REL_LT = 2'd1, REL_GT = 2'd2} rel_t;

  state_t           state;
  state_t           state_nxt;
  rel_t             rel;
  rel_t             rel_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic             flip;
  logic             a_msb;
  logic             b_msb;

  assign a_msb = a_sr[WIDTH-1];
  assign b_msb = b_sr[WIDTH-1];

`ifdef SERIAL_CMP_SIGNED_EN
  logic sgn_q;

  // The sign bit is examined first, while the counter still holds WIDTH.
  assign flip = sgn_q && (cnt == CW'(WIDTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sgn_q <= 1'b0;
    end else if (accept) begin
      sgn_q <= sgn;
    end
  end
`else
  logic unused_sgn;

  assign unused_sgn = sgn;
  assign flip       = 1'b0;
`endif

  // Next-state and relation update.
  always_comb begin
    state_nxt = state;
    rel_nxt   = rel;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if ((rel == REL_EQ) && (a_msb != b_msb)) begin
          rel_nxt = (a_msb ^ flip) ? REL_GT : REL_LT;
        end
        if (cnt == CW'(1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  // Operand shifters, bit counter and sticky relation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sr <= '0;
      b_sr <= '0;
      cnt  <= '0;
      rel  <= REL_EQ;
    end else if (accept) begin
      a_sr <= A;
      b_sr <= B;
      cnt  <= CW'(WIDTH);
      rel  <= REL_EQ;
    end else if (state == RUN) begin
      a_sr <= {a_sr[WIDTH-2:0], 1'b0};
      b_sr <= {b_sr[WIDTH-2:0], 1'b0};
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      rel <= rel_nxt;
    end
  end

  // Result flags change only on entry to DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      L <= 1'b0;
      E <= 1'b1;
      G <= 1'b0;
    end else if (last) begin
      L <= (rel_nxt == REL_LT);
      E <= (rel_nxt == REL_EQ);
      G <= (rel_nxt == REL_GT);
    end
  end

endmodule

// File: tb/tb_serial_magnitude_cmp.sv
// Directed self-checking bench for serial_magnitude_cmp at WIDTH=8 and WIDTH=32.
// Signed expectations follow SERIAL_CMP_SIGNED_EN.
module tb_serial_magnitude_cmp;

  logic        clk = 1'b0;
  logic        reset;
  logic        start8, sgn8, busy8, done8, L8, E8, G8;
  logic [7:0]  a8, b8;
  logic        start32, sgn32, busy32, done32, L32, E32, G32;
  logic [31:0] a32, b32;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  serial_magnitude_cmp #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8), .sgn(sgn8),
    .busy(busy8), .done(done8), .L(L8), .E(E8), .G(G8)
  );

  serial_magnitude_cmp #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .A(a32), .B(b32), .sgn(sgn32),
    .busy(busy32), .done(done32), .L(L32), .E(E32), .G(G32)
  );

  function automatic logic obs_busy(input bit w32);
    return w32 ? busy32 : busy8;
  endfunction

  function automatic logic obs_done(input bit w32);
    return w32 ? done32 : done8;
  endfunction

  function automatic logic [2:0] obs_leg(input bit w32);
    return w32 ? {L32, E32, G32} : {L8, E8, G8};
  endfunction

  task automatic drive(input bit w32, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic st);
    if (w32) begin
      a32 = a; b32 = b; sgn32 = s; start32 = st;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; sgn8 = s; start8 = st;
    end
  endtask

  // Pulse start for one cycle, scramble operands afterwards, collect the outcome.
  task automatic issue(input bit w32, input logic [31:0] a, input logic [31:0] b,
                       input logic s, output int nbusy, output logic seen,
                       output logic [2:0] leg, output logic stuck);
    nbusy = 0;
    seen  = 1'b0;
    leg   = 3'b000;
    stuck = 1'b0;
    @(negedge clk);
    drive(w32, a, b, s, 1'b1);
    @(negedge clk);
    drive(w32, $urandom, $urandom, ~s, 1'b0);
    for (int i = 0; i < 100 && !seen; i++) begin
      if (obs_busy(w32)) nbusy++;
      if (obs_done(w32)) begin
        seen = 1'b1;
        leg  = obs_leg(w32);
      end else begin
        @(negedge clk);
      end
    end
    if (seen) begin
      @(negedge clk);
      stuck = obs_done(w32);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #2;
    compared++; if (busy8 !== 1'b0) begin mismatched++; $display("FAIL reset_busy8: got %b want 0", busy8); end
    compared++; if (done8 !== 1'b0) begin mismatched++; $display("FAIL reset_done8: got %b want 0", done8); end
    compared++; if ({L8, E8, G8} !== 3'b010) begin mismatched++; $display("FAIL reset_leg8: got %b want 010", {L8, E8, G8}); end
    compared++; if (busy32 !== 1'b0) begin mismatched++; $display("FAIL reset_busy32: got %b want 0", busy32); end
    compared++; if ({L32, E32, G32} !== 3'b010) begin mismatched++; $display("FAIL reset_leg32: got %b want 010", {L32, E32, G32}); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_unsigned;
    int nb; logic sn, st; logic [2:0] lg;
    issue(1'b0, 32'h80, 32'h7F, 1'b0, nb, sn, lg, st);
    compared++; if (nb !== 8) begin mismatched++; $display("FAIL u80_busy_cycles: got %0d want 8", nb); end
    compared++; if (sn !== 1'b1) begin mismatched++; $display("FAIL u80_done_seen: got %b want 1", sn); end
    compared++; if (lg !== 3'b001) begin mismatched++; $display("FAIL u80_leg: got %b want 001", lg); end
    compared++; if (st !== 1'b0) begin mismatched++; $display("FAIL u80_done_width: got %b want 0", st); end
    issue(1'b0, 32'h05, 32'h05, 1'b0, nb, sn, lg, st);
    compared++; if (lg !== 3'b010) begin mismatched++; $display("FAIL u05_eq: got %b want 010", lg); end
    issue(1'b0, 32'h12, 32'h34, 1'b0, nb, sn, lg, st);
    compared++; if (lg !== 3'b100) begin mismatched++; $display("FAIL u12_lt: got %b want 100", lg); end
    issue(1'b0, 32'hFF, 32'h01, 1'b0, nb, sn, lg, st);
    compared++; if (lg !== 3'b001) begin mismatched++; $display("FAIL uFF_gt: got %b want 001", lg); end
  endtask

  task automatic test_signed;
    int nb; logic sn, st; logic [2:0] lg; logic [2:0] exp_neg;
`ifdef SERIAL_CMP_SIGNED_EN
    exp_neg = 3'b100;
`else
    exp_neg = 3'b001;
`endif
    issue(1'b0, 32'h80, 32'h7F, 1'b1, nb, sn, lg, st);
    compared++; if (lg !== exp_neg) begin mismatched++; $display("FAIL s80_7F: got %b want %b", lg, exp_neg); end
    issue(1'b0, 32'h80, 32'h7F, 1'b0, nb, sn, lg, st);
    compared++; if (lg !== 3'b001) begin mismatched++; $display("FAIL s80_7F_unsigned: got %b want 001", lg); end
    issue(1'b0, 32'hFF, 32'h01, 1'b1, nb, sn, lg, st);
    compared++; if (lg !== exp_neg) begin mismatched++; $display("FAIL sFF_01: got %b want %b", lg, exp_neg); end
    issue(1'b0, 32'hFE, 32'hFF, 1'b1, nb, sn, lg, st);
    compared++; if (lg !== 3'b100) begin mismatched++; $display("FAIL sFE_FF: got %b want 100", lg); end
    issue(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, nb, sn, lg, st);
    compared++; if (lg !== exp_neg) begin mismatched++; $display("FAIL s32_neg1_0: got %b want %b", lg, exp_neg); end
  endtask

  task automatic test_width32;
    int nb; logic sn, st; logic [2:0] lg;
    issue(1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, nb, sn, lg, st);
    compared++; if (nb !== 32) begin mismatched++; $display("FAIL w32_busy_cycles: got %0d want 32", nb); end
    compared++; if (lg !== 3'b010) begin mismatched++; $display("FAIL w32_eq: got %b want 010", lg); end
    compared++; if (st !== 1'b0) begin mismatched++; $display("FAIL w32_done_width: got %b want 0", st); end
    issue(1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0, nb, sn, lg, st);
    compared++; if (lg !== 3'b100) begin mismatched++; $display("FAIL w32_lsb_lt: got %b want 100", lg); end
  endtask

  task automatic test_retention;
    int nb; logic sn, st; logic [2:0] lg; logic held; logic seen;
    issue(1'b0, 32'h90, 32'h10, 1'b0, nb, sn, lg, st);
    compared++; if (lg !== 3'b001) begin mismatched++; $display("FAIL ret_setup: got %b want 001", lg); end
    @(negedge clk);
    drive(1'b0, 32'h33, 32'h33, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h00, 32'hFF, 1'b0, 1'b0);
    held = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done8) begin
        seen = 1'b1;
        compared++; if ({L8, E8, G8} !== 3'b010) begin mismatched++; $display("FAIL ret_done_eq: got %b want 010", {L8, E8, G8}); end
      end else begin
        if ({L8, E8, G8} !== 3'b001) held = 1'b0;
        @(negedge clk);
      end
    end
    compared++; if (held !== 1'b1) begin mismatched++; $display("FAIL ret_held_during_run: got %b want 1", held); end
    compared++; if (seen !== 1'b1) begin mismatched++; $display("FAIL ret_done_seen: got %b want 1", seen); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pa [2];
    logic [7:0] pb [2];
    logic [2:0] pe [2];
    int k, last_i;
    logic prev_done, stuck;
    pa[0] = 8'h80; pb[0] = 8'h7F; pe[0] = 3'b001;
    pa[1] = 8'h11; pb[1] = 8'hEE; pe[1] = 3'b100;
    k = 0; last_i = 0; prev_done = 1'b0; stuck = 1'b0;
    @(negedge clk);
    drive(1'b0, 32'(pa[0]), 32'(pb[0]), 1'b0, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 80 && k < 4; i++) begin
      if (done8) begin
        if (prev_done) stuck = 1'b1;
        compared++; if ({L8, E8, G8} !== pe[k % 2]) begin mismatched++; $display("FAIL b2b_result%0d: got %b want %b", k, {L8, E8, G8}, pe[k % 2]); end
        if (k > 0) begin
          compared++; if (i - last_i !== 9) begin mismatched++; $display("FAIL b2b_interval%0d: got %0d want 9", k, i - last_i); end
        end
        last_i = i;
        k++;
        a8 = pa[k % 2];
        b8 = pb[k % 2];
        if (k == 4) start8 = 1'b0;
      end else begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end
      prev_done = done8;
      @(negedge clk);
    end
    start8 = 1'b0;
    compared++; if (k !== 4) begin mismatched++; $display("FAIL b2b_count: got %0d want 4", k); end
    compared++; if (done8 !== 1'b0 || stuck !== 1'b0) begin mismatched++; $display("FAIL b2b_done_stuck: got %b want 0", done8 | stuck); end
  endtask

  task automatic test_reset_mid_run;
    int nb; logic sn, st; logic [2:0] lg; logic any_done;
    @(negedge clk);
    drive(1'b0, 32'h80, 32'h7F, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    compared++; if (busy8 !== 1'b0) begin mismatched++; $display("FAIL mid_reset_busy: got %b want 0", busy8); end
    compared++; if (done8 !== 1'b0) begin mismatched++; $display("FAIL mid_reset_done: got %b want 0", done8); end
    compared++; if ({L8, E8, G8} !== 3'b010) begin mismatched++; $display("FAIL mid_reset_leg: got %b want 010", {L8, E8, G8}); end
    @(negedge clk);
    reset = 1'b1;
    any_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) any_done = 1'b1;
    end
    compared++; if (any_done !== 1'b0) begin mismatched++; $display("FAIL mid_reset_no_done: got %b want 0", any_done); end
    issue(1'b0, 32'd3, 32'd5, 1'b0, nb, sn, lg, st);
    compared++; if (lg !== 3'b100) begin mismatched++; $display("FAIL post_reset_lt: got %b want 100", lg); end
    compared++; if (nb !== 8) begin mismatched++; $display("FAIL post_reset_busy: got %0d want 8", nb); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_width32();
    test_retention();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
